// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor
// Per-channel cache performance counters that survive synthesis. For each of
// NCH channels it counts processor accesses (valid and not stalled), miss
// transactions (rising edges of the cache-to-memory request) and memory-busy
// cycles (request high). It also keeps a global count of counted cycles.
// Every counter saturates. Counting can be cleared, and it freezes once
// finish is seen.
//
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   en         : counting enable
//   clr        : synchronous clear of all counters, sat flags and done
//   finish     : freeze request; done sets on the edge that samples it
//   acc_valid  : per-channel processor access request
//   acc_stall  : per-channel cache stall
//   mem_req    : per-channel cache-to-memory request
//   rd_sel     : channel selected for readout
//   rd_acc     : registered access count of the selected channel
//   rd_miss    : registered miss count of the selected channel
//   rd_busy    : registered memory-busy count of the selected channel
//                (all three read 0 when rd_sel >= NCH)
//   cycles     : global counted-cycle count
//   done       : counters frozen
//   sat        : per-channel sticky saturation flag
module cache_perf_monitor #(
    parameter int NCH   = 3,
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             finish,
    input  logic [NCH-1:0]   acc_valid,
    input  logic [NCH-1:0]   acc_stall,
    input  logic [NCH-1:0]   mem_req,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_acc,
    output logic [CNT_W-1:0] rd_miss,
    output logic [CNT_W-1:0] rd_busy,
    output logic [CNT_W-1:0] cycles,
    output logic             done,
    output logic [NCH-1:0]   sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] acc_q  [NCH];
    logic [CNT_W-1:0] acc_d  [NCH];
    logic [CNT_W-1:0] miss_q [NCH];
    logic [CNT_W-1:0] miss_d [NCH];
    logic [CNT_W-1:0] busy_q [NCH];
    logic [CNT_W-1:0] busy_d [NCH];
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] rd_acc_q, rd_acc_d;
    logic [CNT_W-1:0] rd_miss_q, rd_miss_d;
    logic [CNT_W-1:0] rd_busy_q, rd_busy_d;
    logic [NCH-1:0]   req_q, req_d;
    logic [NCH-1:0]   sat_q, sat_d;
    logic             done_q, done_d;

    logic             active;
    logic [NCH-1:0]   acc_ev, miss_ev, busy_ev;

    // Saturating increment: a counter at its maximum holds.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic ev);
        if (ev && (v != CNT_MAX))
            return v + CNT_W'(1);
        return v;
    endfunction

    // True when an event hits a counter that is already pinned at its maximum.
    function automatic logic sat_hit(input logic [CNT_W-1:0] v, input logic ev);
        return ev && (v == CNT_MAX);
    endfunction

    assign active  = en & ~done_q;
    assign acc_ev  = acc_valid & ~acc_stall;
    // req_q tracks mem_req unconditionally, so a request that is already high
    // when counting starts or resumes does not register as a new miss.
    assign miss_ev = mem_req & ~req_q;
    assign busy_ev = mem_req;

    always_comb begin
        acc_d    = acc_q;
        miss_d   = miss_q;
        busy_d   = busy_q;
        cycles_d = cycles_q;
        sat_d    = sat_q;
        done_d   = done_q;
        req_d    = mem_req;

        if (clr) begin
            // Clear wins over counting and over finish on the same edge.
            for (int i = 0; i < NCH; i++) begin
                acc_d[i]  = '0;
                miss_d[i] = '0;
                busy_d[i] = '0;
            end
            cycles_d = '0;
            sat_d    = '0;
            done_d   = 1'b0;
        end else begin
            if (finish && !done_q)
                done_d = 1'b1;
            // active uses the old done, so events on the finish edge still count.
            if (active) begin
                cycles_d = sat_inc(cycles_q, 1'b1);
                for (int i = 0; i < NCH; i++) begin
                    acc_d[i]  = sat_inc(acc_q[i],  acc_ev[i]);
                    miss_d[i] = sat_inc(miss_q[i], miss_ev[i]);
                    busy_d[i] = sat_inc(busy_q[i], busy_ev[i]);
                    if (sat_hit(acc_q[i], acc_ev[i]) || sat_hit(miss_q[i], miss_ev[i]) ||
                        sat_hit(busy_q[i], busy_ev[i]))
                        sat_d[i] = 1'b1;
                end
            end
        end
    end

    // Readout mux; any select outside 0..NCH-1 leaves the outputs at zero.
    always_comb begin
        rd_acc_d  = '0;
        rd_miss_d = '0;
        rd_busy_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_acc_d  = acc_q[i];
                rd_miss_d = miss_q[i];
                rd_busy_d = busy_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                miss_q[i] <= '0;
                busy_q[i] <= '0;
            end
            cycles_q  <= '0;
            rd_acc_q  <= '0;
            rd_miss_q <= '0;
            rd_busy_q <= '0;
            req_q     <= '0;
            sat_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            miss_q    <= miss_d;
            busy_q    <= busy_d;
            cycles_q  <= cycles_d;
            rd_acc_q  <= rd_acc_d;
            rd_miss_q <= rd_miss_d;
            rd_busy_q <= rd_busy_d;
            req_q     <= req_d;
            sat_q     <= sat_d;
            done_q    <= done_d;
        end
    end

    assign rd_acc  = rd_acc_q;
    assign rd_miss = rd_miss_q;
    assign rd_busy = rd_busy_q;
    assign cycles  = cycles_q;
    assign done    = done_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Bench for cache_perf_monitor: a 32-bit instance and a 4-bit instance share
// all inputs, so the narrow one exercises saturation on the same traffic.
module tb_cache_perf_monitor;

    logic        clk = 1'b0;
    logic        rst, en, clr, finish;
    logic [2:0]  acc_valid, acc_stall, mem_req;
    logic [3:0]  rd_sel;

    logic [31:0] d_rd_acc, d_rd_miss, d_rd_busy, d_cycles;
    logic        d_done;
    logic [2:0]  d_sat;
    logic [3:0]  s_rd_acc, s_rd_miss, s_rd_busy, s_cycles;
    logic        s_done;
    logic [2:0]  s_sat;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_perf_monitor #(.NCH(3), .CNT_W(32), .SEL_W(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .finish(finish),
        .acc_valid(acc_valid), .acc_stall(acc_stall), .mem_req(mem_req),
        .rd_sel(rd_sel), .rd_acc(d_rd_acc), .rd_miss(d_rd_miss),
        .rd_busy(d_rd_busy), .cycles(d_cycles), .done(d_done), .sat(d_sat)
    );

    cache_perf_monitor #(.NCH(3), .CNT_W(4), .SEL_W(4)) u_small (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .finish(finish),
        .acc_valid(acc_valid), .acc_stall(acc_stall), .mem_req(mem_req),
        .rd_sel(rd_sel), .rd_acc(s_rd_acc), .rd_miss(s_rd_miss),
        .rd_busy(s_rd_busy), .cycles(s_cycles), .done(s_done), .sat(s_sat)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] acc;
        logic [31:0] miss;
        logic [31:0] busy;
    } rd_vec_t;

    rd_vec_t tbl [5];

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; finish = 1'b0;
        acc_valid = '0; acc_stall = '0; mem_req = '0; rd_sel = '0;

        // Readout table, valid after the access, miss/busy and pre-high phases.
        tbl[0] = '{sel: 4'd0,  acc: 32'd5, miss: 32'd0, busy: 32'd0};
        tbl[1] = '{sel: 4'd1,  acc: 32'd0, miss: 32'd2, busy: 32'd10};
        tbl[2] = '{sel: 4'd2,  acc: 32'd0, miss: 32'd0, busy: 32'd3};
        tbl[3] = '{sel: 4'd3,  acc: 32'd0, miss: 32'd0, busy: 32'd0};
        tbl[4] = '{sel: 4'd15, acc: 32'd0, miss: 32'd0, busy: 32'd0};

        // Reset
        step(); step();
        chk("rst_cycles", d_cycles, 32'd0);
        chk("rst_done", {31'b0, d_done}, 32'd0);
        chk("rst_sat", {29'b0, d_sat}, 32'd0);
        chk("rst_rd_acc", d_rd_acc, 32'd0);
        chk("rst_rd_busy", d_rd_busy, 32'd0);

        // Idle counting
        rst = 1'b0; en = 1'b1;
        repeat (10) step();
        chk("idle_cycles", d_cycles, 32'd10);
        chk("idle_cycles_small", {28'b0, s_cycles}, 32'd10);
        chk("idle_done", {31'b0, d_done}, 32'd0);

        // Access counting: 8 requests on ch0, stalled on the 2nd, 4th, 6th
        rd_sel = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            acc_valid = 3'b001;
            acc_stall = (k == 2 || k == 4 || k == 6) ? 3'b001 : 3'b000;
            step();
        end
        chk("acc_latency", d_rd_acc, 32'd4);
        acc_valid = '0; acc_stall = '0;
        step();
        chk("acc_count", d_rd_acc, 32'd5);
        chk("acc_count_small", {28'b0, s_rd_acc}, 32'd5);
        chk("cycles_19", d_cycles, 32'd19);
        chk("cycles_sat_small", {28'b0, s_cycles}, 32'd15);
        chk("cycles_sat_silent", {29'b0, s_sat}, 32'd0);

        // Miss vs busy on ch1: high 4, low 2, high 6
        rd_sel = 4'd1;
        for (int k = 0; k < 12; k++) begin
            mem_req = (k < 4 || k >= 6) ? 3'b010 : 3'b000;
            step();
        end
        mem_req = '0;
        step();
        chk("miss_ch1", d_rd_miss, 32'd2);
        chk("busy_ch1", d_rd_busy, 32'd10);

        // ch2 request already high when en rises: busy counts, no miss
        en = 1'b0; mem_req = 3'b100;
        step(); step();
        en = 1'b1;
        repeat (3) step();
        en = 1'b0; mem_req = '0;
        step();

        for (int r = 0; r < 5; r++) begin
            rd_sel = tbl[r].sel;
            step();
            chk($sformatf("tbl%0d_acc", r), d_rd_acc, tbl[r].acc);
            chk($sformatf("tbl%0d_miss", r), d_rd_miss, tbl[r].miss);
            chk($sformatf("tbl%0d_busy", r), d_rd_busy, tbl[r].busy);
            chk($sformatf("tbl%0d_busy_small", r), {28'b0, s_rd_busy}, tbl[r].busy);
        end

        // Freeze: 7 accesses on ch2, finish with the 8th, then 5 more
        rd_sel = 4'd2;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cycles", d_cycles, 32'd0);
        chk("clr_done", {31'b0, d_done}, 32'd0);
        en = 1'b1; acc_valid = 3'b100;
        repeat (7) step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("freeze_done", {31'b0, d_done}, 32'd1);
        chk("freeze_cycles", d_cycles, 32'd8);
        repeat (5) step();
        chk("frozen_done", {31'b0, d_done}, 32'd1);
        chk("frozen_cycles", d_cycles, 32'd8);
        chk("frozen_acc", d_rd_acc, 32'd8);
        acc_valid = '0;

        // finish and clr together: clr wins, finish takes effect next edge
        finish = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("fin_clr_done", {31'b0, d_done}, 32'd0);
        chk("fin_clr_cycles", d_cycles, 32'd0);
        step();
        finish = 1'b0;
        chk("fin_after_clr_done", {31'b0, d_done}, 32'd1);
        chk("fin_after_clr_cycles", d_cycles, 32'd1);

        // Saturation: ch0 busy for 20 cycles
        clr = 1'b1;
        step();
        clr = 1'b0; rd_sel = 4'd0; mem_req = 3'b001;
        repeat (20) step();
        mem_req = '0; en = 1'b0;
        step();
        chk("sat_busy_small", {28'b0, s_rd_busy}, 32'd15);
        chk("sat_flag_small", {29'b0, s_sat}, 32'd1);
        chk("sat_miss_small", {28'b0, s_rd_miss}, 32'd1);
        chk("nosat_busy", d_rd_busy, 32'd20);
        chk("nosat_flag", {29'b0, d_sat}, 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat_clr_flag", {29'b0, s_sat}, 32'd0);
        step();
        chk("sat_clr_busy", {28'b0, s_rd_busy}, 32'd0);

        // clr during a busy request on ch1
        en = 1'b1; rd_sel = 4'd1; mem_req = 3'b010;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (2) step();
        mem_req = '0; en = 1'b0;
        step();
        chk("clr_busy_restart", d_rd_busy, 32'd2);
        chk("clr_busy_nomiss", d_rd_miss, 32'd0);

        // rst mid-request: the still-high request counts as a new miss
        en = 1'b1; mem_req = 3'b010;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_cycles", d_cycles, 32'd0);
        repeat (2) step();
        mem_req = '0; en = 1'b0;
        step();
        chk("rst_mid_miss", d_rd_miss, 32'd1);
        chk("rst_mid_busy", d_rd_busy, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_perf_monitor.md
# cache_perf_monitor

Synthesizable, parametrised performance monitor that sits beside the CHIP's caches and counts per-channel cache accesses, miss transactions and memory-busy cycles, plus a global cycle count. It generalises the access/miss bookkeeping the final-project bench does in simulation to `NCH` channels (e.g. I-read, D-read, D-write) with saturating counters, clear, freeze-on-finish and a registered readout port. The statistics therefore survive synthesis and are visible post-layout.

## Interface
- `NCH`, 3: number of monitored channels (1..16)
- `CNT_W`, 32: width of every counter
- `SEL_W`, 4: width of readout select

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  counting enable
- `clr`  in  1  synchronous clear of all counters and of `done`
- `finish`  in  1  freeze request (testbed finish)
- `acc_valid`  in  NCH  per-channel processor access request (proc_read / proc_write)
- `acc_stall`  in  NCH  per-channel cache stall
- `mem_req`  in  NCH  per-channel cache-to-memory request (mem_read / mem_write)
- `rd_sel`  in  SEL_W  channel to read out
- `rd_acc`  out  CNT_W  access count of selected channel
- `rd_miss`  out  CNT_W  miss count of selected channel
- `rd_busy`  out  CNT_W  memory-busy cycles of selected channel
- `cycles`  out  CNT_W  global counted-cycle count
- `done`  out  1  counters frozen
- `sat`  out  NCH  per-channel sticky saturation flag (any of its three counters)

## Operation
- Per channel `i`, evaluated at each rising edge while `active = en & ~done`:
  - access event: `acc_valid[i] & ~acc_stall[i]` -> `acc[i] += 1`
  - miss event: `mem_req[i] & ~req_q[i]` (rising edge) -> `miss[i] += 1`
  - busy event: `mem_req[i]` -> `busy[i] += 1`
- `cycles += 1` every edge while `active`.
- `req_q[i]` <= `mem_req[i]` every edge regardless of `en`, `done` or `clr`, so a request already high when counting starts or resumes is not counted as a new miss. It is 0 only after `rst`.
- Saturation: a counter at `2^CNT_W-1` holds its value. The owning `sat[i]` bit sets and stays set until `clr`/`rst`. `cycles` saturates silently.
- Freeze: `finish` high at an edge with `done=0` -> `done` <= 1. Events sampled at that same edge are still counted. From the next edge onward all counters hold.
- Priority, highest first: `rst` > `clr` > counting. `clr` zeroes `acc`, `miss`, `busy`, `cycles`, `sat` and `done`. Events on a `clr` edge are dropped.
- `finish` and `clr` on the same edge: `clr` wins and `done`=0. If `finish` is still high on the next edge, `done` sets then.
- Readout: `rd_*` <= counters of channel `rd_sel`, registered. `rd_sel >= NCH` -> all `rd_*` = 0.

## Timing
- Reset values: all counters 0, `req_q` 0, `rd_acc`/`rd_miss`/`rd_busy`/`cycles` 0, `done` 0, `sat` 0.
- Event sampled at edge N -> internal counter updated at edge N.
- `cycles` is a direct register output and is visible after edge N.
- `rd_*` reflect the counter value after edge N-1, i.e. readout latency is 1 cycle from both `rd_sel` change and counter update.
- `done` is visible after the edge that sampled `finish`.
- A `rst` mid-transaction clears all state in one edge. A `mem_req` still high afterwards counts as a new miss, because `req_q`=0.

## Test plan
- Reset/idle: `rst` 1 for 2 cycles, then `en`=1 with no events for 10 cycles -> `cycles`=10, all `rd_*`=0 for every `rd_sel`, `done`=0, `sat`=0.
- Access counting: ch0 `acc_valid`=1 for 8 cycles with `acc_stall`=1 on 3 of them -> `rd_acc`(sel 0)=5 one cycle after the last access. Other channels read 0.
- Miss vs busy: ch1 `mem_req` high 4 cycles, low 2, high 6 -> `rd_miss`=2, `rd_busy`=10. `mem_req` already high when `en` rises -> no miss counted for that request.
- Freeze: 7 accesses on ch2, then `finish` coincident with an 8th access, then 5 more -> `rd_acc`=8, `done`=1, `cycles` stops. `finish`+`clr` on the same edge -> `done`=0.
- Saturation: `CNT_W`=4, ch0 busy for 20 cycles -> `rd_busy`=15, `sat[0]`=1. `clr` -> 0 and `sat`=0.
- Readout/clear: `rd_sel`=NCH -> zeros. `clr` during a busy request -> busy restarts from 0 on the next edge and `miss` is not incremented.
